axi_header_arbiter: RTL and testbench

AXI_HEADER_ARBITER -- requirements
Module: axi_header_arbiter

---
 rtl/axi_header_arbiter.sv | 112 +++++++++++
 tb/tb_axi_header_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_header_arbiter.sv
// Round-robin arbiter that picks one header requester at a time, offers its header to the
// insert-header datapath, and waits for the packet's end-of-packet beat before the next grant.
module axi_header_arbiter #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned NUM_REQ      = 4,
  localparam int unsigned ID_WD       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]     req_data,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0] req_byte_cnt,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           valid_insert,
  output logic [DATA_WD-1:0]             data_insert,
  output logic [DATA_BYTE_WD-1:0]        keep_insert,
  output logic [BYTE_CNT_WD-1:0]         byte_insert_cnt,
  input  logic                           ready_insert,
  input  logic                           mon_valid,
  input  logic                           mon_ready,
  input  logic                           mon_last,
  output logic [ID_WD-1:0]               grant_id,
  output logic                           busy,
  output logic [15:0]                    pkt_cnt
);

  typedef enum logic [1:0] {StIdle, StOffer, StWaitEop} state_e;

  state_e                  state;
  logic [ID_WD-1:0]        rr_ptr;
  logic                    sel_found;
  logic [ID_WD-1:0]        sel_id;
  logic [DATA_WD-1:0]      sel_data;
  logic [BYTE_CNT_WD-1:0]  sel_cnt;
  logic [DATA_BYTE_WD-1:0] sel_keep;
  logic [DATA_BYTE_WD-1:0] all_ones;
  int unsigned             idx;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_WD'(idx);
      end
    end
  end

  always_comb begin
    all_ones = '1;
    sel_data = req_data[32'(sel_id) * DATA_WD +: DATA_WD];
    sel_cnt  = req_byte_cnt[32'(sel_id) * BYTE_CNT_WD +: BYTE_CNT_WD];
    sel_keep = all_ones >> (DATA_BYTE_WD - 1 - 32'(sel_cnt));
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == StIdle && sel_found) begin
      req_ready[sel_id] = 1'b1;
    end
  end

  assign busy = (state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= StIdle;
      valid_insert    <= 1'b0;
      data_insert     <= '0;
      keep_insert     <= '0;
      byte_insert_cnt <= '0;
      grant_id        <= '0;
      pkt_cnt         <= '0;
      rr_ptr          <= ID_WD'(NUM_REQ - 1);
    end else begin
      unique case (state)
        StIdle: begin
          if (sel_found) begin
            data_insert     <= sel_data;
            keep_insert     <= sel_keep;
            byte_insert_cnt <= sel_cnt;
            grant_id        <= sel_id;
            rr_ptr          <= sel_id;
            valid_insert    <= 1'b1;
            state           <= StOffer;
          end
        end
        StOffer: begin
          // Monitor events are deliberately ignored until the header has been accepted.
          if (ready_insert) begin
            valid_insert <= 1'b0;
            state        <= StWaitEop;
          end
        end
        StWaitEop: begin
          if (mon_valid && mon_ready && mon_last) begin
            pkt_cnt <= pkt_cnt + 16'd1;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_header_arbiter.sv
// Directed bench for axi_header_arbiter: stimulus pushes expected headers into a queue and a
// negedge monitor pops and compares them on every header handshake.
module tb_axi_header_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [7:0]  req_byte_cnt;
  logic [3:0]  req_ready;
  logic        valid_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic [1:0]  byte_insert_cnt;
  logic        ready_insert;
  logic        mon_valid, mon_ready, mon_last;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] pkt_cnt;

  axi_header_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_byte_cnt    (req_byte_cnt),
    .req_ready       (req_ready),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .mon_valid       (mon_valid),
    .mon_ready       (mon_ready),
    .mon_last        (mon_last),
    .grant_id        (grant_id),
    .busy            (busy),
    .pkt_cnt         (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [31:0] data;
    logic [3:0]  keep;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  // Hand-written header table: data, byte count minus one, and the matching keep.
  logic [31:0] hdr [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
  logic [1:0]  bc  [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
  logic [3:0]  kp  [4] = '{4'b1111, 4'b0001, 4'b0111, 4'b0011};

  int checks = 0;
  int errors = 0;
  int bench_ptr = 3;
  int exp_pkt = 0;
  bit expect_eop = 1'b0;
  logic [15:0] last_pkt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mon(input logic v);
    mon_valid = v;
    mon_ready = v;
    mon_last  = v;
  endtask

  function automatic int rr_pick(input int ptr, input logic [3:0] vld);
    for (int k = 1; k <= 4; k++) begin
      if (vld[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Monitor: header payload, header/EOP alternation, no grants while busy.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expect_eop = 1'b0;
      last_pkt   = '0;
    end else begin
      if (busy) chk("ready_while_busy", 64'(req_ready), 64'd0);
      if (valid_insert && ready_insert) begin
        chk("hdr_before_eop", 64'(expect_eop), 64'd0);
        expect_eop = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_hdr", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("grant_id", 64'(grant_id), 64'(e.id));
          chk("data_insert", 64'(data_insert), 64'(e.data));
          chk("keep_insert", 64'(keep_insert), 64'(e.keep));
          chk("byte_insert_cnt", 64'(byte_insert_cnt), 64'(e.cnt));
        end
      end
      if (pkt_cnt != last_pkt) begin
        chk("eop_without_hdr", 64'(expect_eop), 64'd1);
        expect_eop = 1'b0;
        last_pkt   = pkt_cnt;
      end
    end
  end

  task automatic run_pkt(input int exp_id, input logic [3:0] vld, input int stall,
                         input bit mon_early, input bit drop);
    int waited;
    logic [3:0] exp_rdy;
    exp_q.push_back('{id: exp_id, data: hdr[exp_id], keep: kp[exp_id], cnt: bc[exp_id]});
    req_valid = vld;
    #1;
    waited = 0;
    while (req_ready == 4'd0 && waited < 20) begin
      tick();
      waited++;
    end
    exp_rdy = 4'b0001 << exp_id;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    tick();
    if (drop) req_valid = '0;
    #1;
    chk("req_ready_offer", 64'(req_ready), 64'd0);
    for (int s = 0; s < stall; s++) begin
      if (mon_early) set_mon(1'b1);
      chk("valid_stall", 64'(valid_insert), 64'd1);
      chk("data_stall", 64'(data_insert), 64'(hdr[exp_id]));
      chk("keep_stall", 64'(keep_insert), 64'(kp[exp_id]));
      tick();
    end
    chk("valid_offer", 64'(valid_insert), 64'd1);
    if (mon_early) set_mon(1'b1);
    ready_insert = 1'b1;
    tick();
    ready_insert = 1'b0;
    set_mon(1'b0);
    chk("valid_after_accept", 64'(valid_insert), 64'd0);
    chk("busy_wait_eop", 64'(busy), 64'd1);
    chk("pkt_hold", 64'(pkt_cnt), 64'(exp_pkt));
    set_mon(1'b1);
    tick();
    set_mon(1'b0);
    exp_pkt = (exp_pkt + 1) % 65536;
    chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
    chk("busy_after_eop", 64'(busy), 64'd0);
    bench_ptr = exp_id;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b1111;
    ready_insert = 1'b0;
    set_mon(1'b0);
    for (int i = 0; i < 4; i++) begin
      req_data[i*32 +: 32]   = hdr[i];
      req_byte_cnt[i*2 +: 2] = bc[i];
    end
    tick();
    tick();
    chk("rst_valid_insert", 64'(valid_insert), 64'd0);
    chk("rst_data_insert", 64'(data_insert), 64'd0);
    chk("rst_keep_insert", 64'(keep_insert), 64'd0);
    chk("rst_byte_cnt", 64'(byte_insert_cnt), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    // All requesters held valid: strict rotation 0,1,2,3,0.
    run_pkt(0, 4'b1111, 0, 1'b0, 1'b0);
    run_pkt(1, 4'b1111, 0, 1'b0, 1'b0);
    run_pkt(2, 4'b1111, 0, 1'b0, 1'b0);
    run_pkt(3, 4'b1111, 0, 1'b0, 1'b0);
    run_pkt(0, 4'b1111, 0, 1'b0, 1'b0);
    chk("pkt_cnt_five", 64'(pkt_cnt), 64'd5);

    // Lone requester 3 wins twice in a row.
    run_pkt(3, 4'b1000, 0, 1'b0, 1'b0);
    run_pkt(3, 4'b1000, 1, 1'b0, 1'b0);

    // Back-pressure for 3 cycles on requester 2 (cnt 2 -> keep 0111).
    run_pkt(2, 4'b0100, 3, 1'b0, 1'b0);

    // EOP pulses during OFFER and on the accept cycle are ignored; requester drops valid.
    run_pkt(0, 4'b0001, 2, 1'b1, 1'b1);
    chk("pkt_cnt_nine", 64'(pkt_cnt), 64'd9);

    // Reset while waiting for EOP abandons the grant.
    exp_q.push_back('{id: 1, data: hdr[1], keep: kp[1], cnt: bc[1]});
    req_valid = 4'b0010;
    #1;
    chk("req_ready_pre_rst", 64'(req_ready), 64'b0010);
    tick();
    ready_insert = 1'b1;
    tick();
    ready_insert = 1'b0;
    chk("busy_pre_rst", 64'(busy), 64'd1);
    rst = 1'b1;
    req_valid = 4'b0110;
    tick();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(valid_insert), 64'd0);
    chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("mid_rst_grant", 64'(grant_id), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    exp_pkt = 0;
    bench_ptr = 3;
    run_pkt(1, 4'b0110, 0, 1'b0, 1'b0);

    // Short randomized run checked against the bench's own round-robin model.
    for (int n = 0; n < 12; n++) begin
      logic [3:0] vld;
      int id;
      vld = 4'($urandom_range(1, 15));
      id = rr_pick(bench_ptr, vld);
      run_pkt(id, vld, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    req_valid = '0;
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
